// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter between the AXI write and read sides for a
// single shared APB sequencer. It grants one transfer at a time, steers the
// p_write/address/data muxes through sel_write, and flags transfers that run
// longer than TIMEOUT APB clock-enable ticks.
module apb_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wr_req,
    input  logic rd_req,
    output logic wr_done,
    output logic rd_done,
    output logic sel_write,
    output logic req,
    input  logic done,
    input  logic p_clk_en,
    output logic busy,
    output logic timeout
);

    // Tick counter is wide enough to hold TIMEOUT itself (it saturates there).
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;         // 1 = write side, 0 = read side
    logic          last_served_q, last_served_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    // State and arbitration registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_served_q <= 1'b0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for done in BUSY, count ticks.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;

        unique case (state_q)
            IDLE: begin
                // done arriving here is ignored entirely.
                if (wr_req || rd_req) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    if (wr_req && rd_req)
                        owner_d = ~last_served_q;
                    else
                        owner_d = wr_req;
                end
            end
            BUSY: begin
                // Requests are not re-sampled here: a dropped request still
                // runs to done.
                if (done) begin
                    state_d       = IDLE;
                    last_served_d = owner_q;
                end else if (p_clk_en && (cnt_q != TMAX)) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMAX)
                        timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: done pulses are combinational on done, qualified by BUSY.
    always_comb begin
        busy      = (state_q == BUSY);
        req       = busy & ~done;
        wr_done   = busy & done & owner_q;
        rd_done   = busy & done & ~owner_q;
        sel_write = owner_q;
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed vectors for apb_arbiter with TIMEOUT=4.
// Inputs are driven just after the falling edge; outputs are sampled there too.
module tb_apb_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic wr_req, rd_req, done, p_clk_en;
    logic wr_done, rd_done, sel_write, req, busy, timeout;

    int n_vec = 0;
    int n_err = 0;
    int ticks;

    apb_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .sel_write (sel_write),
        .req       (req),
        .done      (done),
        .p_clk_en  (p_clk_en),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        done     = 1'b0;
        p_clk_en = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_sel", sel_write, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Both sides requesting: strict alternation starting with write.
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_busy", busy, 1);
            check("rr_sel", sel_write, (i % 2 == 0) ? 1 : 0);
            check("rr_req", req, 1);
            done = 1'b1;
            #1;
            check("rr_wr_done", wr_done, (i % 2 == 0) ? 1 : 0);
            check("rr_rd_done", rd_done, (i % 2 == 0) ? 0 : 1);
            check("rr_req_done", req, 0);
            @(negedge clk);
            done = 1'b0;
            #1;
            check("rr_gap_idle", busy, 0);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Read only, done five cycles after grant.
        @(negedge clk);
        rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rd_req_hi", req, 1);
            check("rd_sel", sel_write, 0);
            check("rd_no_done", rd_done, 0);
        end
        done = 1'b1;
        #1;
        check("rd_req_lo", req, 0);
        check("rd_done_pulse", rd_done, 1);
        check("rd_wr_done", wr_done, 0);
        rd_req = 1'b0;
        @(negedge clk);
        done = 1'b0;
        #1;
        check("rd_busy_after", busy, 0);
        check("rd_done_single", rd_done, 0);
        check("rd_sel_hold", sel_write, 0);

        // done while idle is ignored.
        @(negedge clk);
        done = 1'b1;
        #1;
        check("idle_wr_done", wr_done, 0);
        check("idle_rd_done", rd_done, 0);
        check("idle_req", req, 0);
        @(negedge clk);
        check("idle_stays", busy, 0);
        done = 1'b0;

        // Write request dropped mid-transfer still completes.
        wr_req = 1'b1;
        @(negedge clk);
        check("drop_busy", busy, 1);
        check("drop_sel", sel_write, 1);
        wr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drop_req_hi", req, 1);
            check("drop_busy_hi", busy, 1);
        end
        done = 1'b1;
        #1;
        check("drop_wr_done", wr_done, 1);
        @(negedge clk);
        done = 1'b0;
        #1;
        check("drop_idle", busy, 0);
        check("drop_sel_hold", sel_write, 1);

        // Reset during a write transfer: asynchronous, no done pulse.
        wr_req = 1'b1;
        @(negedge clk);
        check("rstb_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        done    = 1'b1;
        #1;
        check("rstb_req", req, 0);
        check("rstb_busy0", busy, 0);
        check("rstb_sel", sel_write, 0);
        check("rstb_wr_done", wr_done, 0);
        wr_req = 1'b0;
        done   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // After reset both requesting: write first even though write was last.
        wr_req = 1'b1;
        rd_req = 1'b1;
        @(negedge clk);
        check("post_rst_sel", sel_write, 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        done   = 1'b1;
        #1;
        check("post_rst_wr_done", wr_done, 1);
        @(negedge clk);
        done = 1'b0;

        // Timeout: tick every second cycle, no done for ten ticks.
        rd_req = 1'b1;
        @(negedge clk);
        check("to_busy", busy, 1);
        rd_req = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("to_flag", timeout, (ticks >= 4) ? 1 : 0);
            p_clk_en = (i % 2 == 0);
            if (p_clk_en) ticks++;
        end
        @(negedge clk);
        p_clk_en = 1'b0;
        check("to_set", timeout, 1);
        check("to_not_abort", busy, 1);
        done = 1'b1;
        #1;
        check("to_rd_done", rd_done, 1);
        @(negedge clk);
        done = 1'b0;
        #1;
        check("to_sticky", timeout, 1);
        check("to_idle", busy, 0);
        reset_n = 1'b0;
        #1;
        check("to_cleared", timeout, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 256, meaning p_clk_en ticks in BUSY without done before timeout sets; 0 disables the timeout.
REQ-002 Port clk, input, 1 bit, meaning the single block clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 Port wr_req, input, 1 bit, meaning the AXI write side requests one APB transfer; held high until wr_done.
REQ-005 Port rd_req, input, 1 bit, meaning the AXI read side requests one APB transfer; held high until rd_done.
REQ-006 Port wr_done, output, 1 bit, meaning a one-cycle pulse that the write transfer completed.
REQ-007 Port rd_done, output, 1 bit, meaning a one-cycle pulse that the read transfer completed.
REQ-008 Port sel_write, output, 1 bit, meaning current owner (1=write, 0=read); it steers the p_write, address and data muxes.
REQ-009 Port req, output, 1 bit, meaning the transfer request to the APB sequencer.
REQ-010 Port done, input, 1 bit, meaning the sequencer completion pulse (already qualified by p_clk_en and p_ready).
REQ-011 Port p_clk_en, input, 1 bit, meaning the APB clock-enable tick.
REQ-012 Port busy, output, 1 bit, meaning a transfer is granted and in flight.
REQ-013 Port timeout, output, 1 bit, meaning a sticky flag that a transfer exceeded TIMEOUT ticks.

Function
REQ-014 The arbiter SHALL implement two states, IDLE and BUSY, plus the registers owner, last_served, tick counter and timeout flag.
REQ-015 In IDLE, if wr_req or rd_req is high, the arbiter SHALL latch owner and enter BUSY on the next clk edge, regardless of p_clk_en.
REQ-016 With only one request high, that request SHALL win.
REQ-017 With both requests high, the requester other than last_served SHALL win (round-robin).
REQ-018 req SHALL equal (state==BUSY) & ~done, so that req is low in the completion cycle and the sequencer returns to idle.
REQ-019 sel_write SHALL equal the owner register, SHALL be stable for the whole of BUSY, and SHALL hold its value in IDLE.
REQ-020 In BUSY with done=1, wr_done SHALL equal owner and rd_done SHALL equal ~owner, both combinational in the same cycle as done.
REQ-021 At the next edge after done, state SHALL become IDLE and last_served SHALL take the value of owner.
REQ-022 done received in IDLE SHALL be ignored: no done pulse, no state change.
REQ-023 wr_done and rd_done SHALL never be high simultaneously, and never outside BUSY.
REQ-024 Deassertion of the owner's request during BUSY SHALL be ignored; the transfer runs to done.
REQ-025 The minimum gap between back-to-back grants SHALL be one IDLE cycle; a request still high in that IDLE cycle re-arbitrates normally.
REQ-026 busy SHALL equal (state==BUSY).
REQ-027 The tick counter SHALL clear on entry to BUSY and increment on each p_clk_en in BUSY without done, saturating at TIMEOUT.
REQ-028 When the tick counter reaches TIMEOUT (nonzero), timeout SHALL set and stay set until reset; the transfer is not aborted.

Reset
REQ-029 Asserting reset_n low SHALL immediately force state=IDLE, owner=0, last_served=0 (read), counter=0 and timeout=0, so that req=0, busy=0, both done outputs=0 and sel_write=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no done pulse; the requester is reset by the same reset_n.
REQ-031 After reset, with both requests high, write SHALL win first.

Verification
REQ-032 Reset, then wr_req=rd_req=1 together -> grants write, read, write, read in strict alternation; sel_write 1,0,1,0.
REQ-033 rd_req only, done 5 cycles after grant -> sel_write=0, req high 5 cycles then low in the done cycle, rd_done a single pulse, busy low the next cycle.
REQ-034 done pulsed while IDLE -> wr_done=rd_done=0, state unchanged.
REQ-035 TIMEOUT=4, p_clk_en every 2nd cycle, no done for 10 ticks -> timeout rises on the 4th tick and stays high after a later done; only reset clears it.
REQ-036 reset_n low while BUSY(write) -> req, busy and sel_write go 0 asynchronously; no wr_done pulse.
REQ-037 wr_req dropped mid-BUSY -> req stays high until done; wr_done still pulses.
